dbg_frame_packer: RTL and testbench
===================================

// Module: dbg_frame_packer
// PURPOSE
//  Converts a stream of 32-bit words into dbg_bridge UART write-command frames.
//  Each frame is: CMD, LEN, ADDR[31:24..7:0], then LEN data bytes.
//  Long transfers are split into frames of at most MAX_LEN bytes, with the address auto-incremented.
//  Sits between a word source (image ROM/DMA) and the dbg_bridge_fifo -> UART TX path.
// PARAMETERS
//  MAX_LEN        128    max data bytes per frame; multiple of 4, range 4..252
//  CMD_WRITE      8'h10  command byte emitted first in every frame
//  DATA_MSB_FIRST 1      1: data byte order [31:24] first; 0: [7:0] first
//  CNT_W          16     width of the word-count and frame-count fields
// PORTS
//  clk_i           in   1      clock
//  rst_i           in   1      synchronous reset, active-high
//  start_i         in   1      1-cycle request; sampled only in IDLE
//  base_addr_i     in   32     byte address of first word; sampled with start_i
//  total_words_i   in   CNT_W  number of words to send; sampled with start_i
//  busy_o          out  1      high from the cycle after an accepted start until done
//  done_o          out  1      1-cycle pulse when the transfer completes
//  frame_count_o   out  CNT_W  frames emitted in current/last transfer
//  word_valid_i    in   1      source word valid
//  word_data_i     in   32     source word
//  word_accept_o   out  1      word consumed this cycle (word_valid_i & word_accept_o)
//  byte_valid_o    out  1      output byte valid
//  byte_data_o     out  8      output byte
//  byte_accept_i   in   1      sink accepts byte (e.g. fifo accept_o)
// BEHAVIOUR
//  - Reset values: busy_o=0, done_o=0, frame_count_o=0, word_accept_o=0, byte_valid_o=0,
//    byte_data_o=0. Reset mid-frame abandons the partial frame; no further bytes are emitted.
//  - Byte handshake: a transfer occurs when byte_valid_o & byte_accept_i.
//    Once asserted, byte_valid_o and byte_data_o hold stable until the byte is accepted.
//  - FSM: IDLE -> CMD -> LEN -> ADDR(4 bytes, MSB first) -> DATA -> (NEXT frame: CMD | DONE) -> IDLE.
//    Each state advances only on an accepted byte.
//  - Frame length: len = min(MAX_LEN, 4*remaining_words). It is computed on entry to CMD.
//    The len byte is emitted as 8 bits.
//  - Address: the first frame uses base_addr_i. Each following frame uses prev_addr + prev_len,
//    with 32-bit wrap-around and no error.
//  - DATA: a 32-bit word register plus a 2-bit byte index.
//    - word_accept_o=1 only in DATA while the register is empty.
//    - byte_valid_o=0 while the register is empty; a source stall therefore stalls the output.
//    - The register empties once the 4th byte is accepted.
//    - Accepting a new word in that same cycle is allowed, giving zero-bubble streaming.
//  - DATA exits once len bytes are accepted. remaining_words decrements by len/4.
//    frame_count_o increments when each frame ends.
//  - DONE: done_o=1 for one cycle; busy_o falls in the same cycle; return to IDLE.
//  - total_words_i=0: no bytes emitted; done_o pulses the cycle after start; frame_count_o=0.
//  - start_i is ignored when not in IDLE. frame_count_o clears on an accepted start.
//  - Latency: the first CMD byte is valid on the cycle after an accepted start.
// STRUCTURE
//  - Package dbg_frame_pkg holds:
//    - state enum {IDLE,CMD,LEN,ADDR,DATA,DONE}
//    - DBG_CMD_WRITE / DBG_CMD_READ constants
//    - the ADDR_BYTES=4 localparam
//  - Single module; no sub-module is warranted.
//  - The downstream dbg_bridge_fifo and UART are instantiated by the parent.
// TESTING
//  1. base=0x1000_0000, words=2 {0xAABBCCDD,0x11223344}, MSB first
//     -> 10 08 10 00 00 00 AA BB CC DD 11 22 33 44; done 1 cycle after last byte.
//  2. base=0x0, words=40 -> frame0: 10 80 00 00 00 00 + 128 B; frame1: 10 20 00 00 00 80 + 32 B;
//     frame_count_o=2.
//  3. Case 2 with byte_accept_i random 30%
//     -> identical byte sequence; data stable while valid and not accepted.
//  4. words=0 -> zero bytes, done_o pulse the cycle after start_i, busy_o never high.
//  5. word_valid_i low for 10 cycles mid-DATA -> byte_valid_o low, resumes with correct byte;
//     DATA_MSB_FIRST=0 reverses order.
//  6. rst_i during frame1 ADDR -> outputs at reset values next edge; a new start emits a clean frame.

Source files
------------

// File: rtl/dbg_frame_pkg.sv
// dbg_frame_pkg
//  Shared types and constants for the dbg_bridge write-frame packer.
//  - state_t      : packer FSM states
//  - DBG_CMD_*    : dbg_bridge command bytes
//  - ADDR_BYTES   : number of address bytes in a frame header
//  - calc_len     : data bytes in the next frame for a given remaining word count
package dbg_frame_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      LEN,
      ADDR,
      DATA,
      DONE
   } state_t;

   localparam logic [7:0] DBG_CMD_WRITE = 8'h10;
   localparam logic [7:0] DBG_CMD_READ  = 8'h11;
   localparam int         ADDR_BYTES    = 4;

   // len = min(max_len, 4*rem_words). Below max_len the word count is < 63,
   // so the low 6 bits times four are the whole answer.
   function automatic logic [7:0] calc_len(input logic [31:0] rem_words, input int max_len);
      if (rem_words >= 32'(max_len / 4)) begin
         return 8'(max_len);
      end
      return {rem_words[5:0], 2'b00};
   endfunction

endpackage

// File: rtl/dbg_frame_packer_if.sv
// dbg_frame_packer_if
//  Groups the packer's control, word-source and byte-sink signals.
//  slave  : the packer side (takes start/words/byte_accept, drives status/bytes)
//  master : the environment side (parent control, word source, byte sink)
interface dbg_frame_packer_if #(
   parameter int CNT_W = 16
);
   // control / status
   logic             start_i;
   logic [31:0]      base_addr_i;
   logic [CNT_W-1:0] total_words_i;
   logic             busy_o;
   logic             done_o;
   logic [CNT_W-1:0] frame_count_o;
   // word source
   logic             word_valid_i;
   logic [31:0]      word_data_i;
   logic             word_accept_o;
   // byte sink
   logic             byte_valid_o;
   logic [7:0]       byte_data_o;
   logic             byte_accept_i;

   modport slave (
      input  start_i, base_addr_i, total_words_i, word_valid_i, word_data_i, byte_accept_i,
      output busy_o, done_o, frame_count_o, word_accept_o, byte_valid_o, byte_data_o
   );

   modport master (
      output start_i, base_addr_i, total_words_i, word_valid_i, word_data_i, byte_accept_i,
      input  busy_o, done_o, frame_count_o, word_accept_o, byte_valid_o, byte_data_o
   );

endinterface

// File: rtl/dbg_frame_packer.sv
// dbg_frame_packer
//  Turns a stream of 32-bit words into dbg_bridge write frames:
//  CMD, LEN, ADDR[31:24..7:0], LEN data bytes. Transfers longer than MAX_LEN
//  bytes are split into several frames with the address advanced by each
//  frame's length (32-bit wrap).
// Ports
//  clk_i, rst_i : clock, synchronous active-high reset
//  bus (slave)  : start/base_addr/total_words in, busy/done/frame_count out,
//                 word_valid/word_data in, word_accept out,
//                 byte_valid/byte_data out, byte_accept in
// Byte outputs are a function of registered state only, so they stay stable
// while the sink stalls. word_accept_o also looks at byte_accept_i so a new
// word can be loaded in the same cycle the 4th byte of the old one leaves.
module dbg_frame_packer
   import dbg_frame_pkg::*;
#(
   parameter int         MAX_LEN        = 128,
   parameter logic [7:0] CMD_WRITE      = DBG_CMD_WRITE,
   parameter bit         DATA_MSB_FIRST = 1'b1,
   parameter int         CNT_W          = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   dbg_frame_packer_if.slave  bus
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;       // words still to send
   logic [31:0]      addr_q, addr_d;     // address of the current frame
   logic [7:0]       len_q, len_d;       // data bytes in the current frame
   logic [7:0]       cnt_q, cnt_d;       // byte position within ADDR / DATA
   logic [CNT_W-1:0] fcnt_q, fcnt_d;
   logic [31:0]      word_q, word_d;
   logic             full_q, full_d;
   logic [1:0]       idx_q, idx_d;       // next byte of word_q to emit

   logic             byte_valid;
   logic [7:0]       byte_data;
   logic             word_accept;
   logic             last_byte;
   logic [CNT_W-1:0] rem_new;
   logic [1:0]       sel;

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      addr_d      = addr_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      fcnt_d      = fcnt_q;
      word_d      = word_q;
      full_d      = full_q;
      idx_d       = idx_q;
      byte_valid  = 1'b0;
      byte_data   = 8'h00;
      word_accept = 1'b0;
      last_byte   = (cnt_q == len_q - 8'd1);
      rem_new     = rem_q - CNT_W'(len_q[7:2]);
      sel         = DATA_MSB_FIRST ? ~idx_q : idx_q;

      case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               fcnt_d = '0;
               addr_d = bus.base_addr_i;
               rem_d  = bus.total_words_i;
               len_d  = calc_len(32'(bus.total_words_i), MAX_LEN);
               state_d = (bus.total_words_i == '0) ? DONE : CMD;
            end
         end
         CMD: begin
            byte_valid = 1'b1;
            byte_data  = CMD_WRITE;
            if (bus.byte_accept_i) state_d = LEN;
         end
         LEN: begin
            byte_valid = 1'b1;
            byte_data  = len_q;
            if (bus.byte_accept_i) begin
               state_d = ADDR;
               cnt_d   = '0;
            end
         end
         ADDR: begin
            byte_valid = 1'b1;
            byte_data  = addr_q[{~cnt_q[1:0], 3'b000} +: 8];
            if (bus.byte_accept_i) begin
               if (cnt_q == 8'(ADDR_BYTES - 1)) begin
                  state_d = DATA;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         DATA: begin
            byte_valid = full_q;
            byte_data  = word_q[{sel, 3'b000} +: 8];
            // Refill when empty, or in the cycle the last byte of a word
            // leaves (unless that byte also ends the frame).
            word_accept = !full_q ||
                          (idx_q == 2'd3 && bus.byte_accept_i && !last_byte);
            if (full_q && bus.byte_accept_i) begin
               cnt_d = cnt_q + 8'd1;
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) full_d = 1'b0;
               if (last_byte) begin
                  rem_d   = rem_new;
                  fcnt_d  = fcnt_q + 1'b1;
                  addr_d  = addr_q + 32'(len_q);
                  len_d   = calc_len(32'(rem_new), MAX_LEN);
                  cnt_d   = '0;
                  state_d = (rem_new == '0) ? DONE : CMD;
               end
            end
            if (word_accept && bus.word_valid_i) begin
               word_d = bus.word_data_i;
               full_d = 1'b1;
               idx_d  = '0;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         rem_q   <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         fcnt_q  <= '0;
         word_q  <= '0;
         full_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         fcnt_q  <= fcnt_d;
         word_q  <= word_d;
         full_q  <= full_d;
         idx_q   <= idx_d;
      end
   end

   assign bus.byte_valid_o  = byte_valid;
   assign bus.byte_data_o   = byte_data;
   assign bus.word_accept_o = word_accept;
   assign bus.busy_o        = (state_q == CMD) || (state_q == LEN) ||
                              (state_q == ADDR) || (state_q == DATA);
   assign bus.done_o        = (state_q == DONE);
   assign bus.frame_count_o = fcnt_q;

endmodule

// File: tb/tb_dbg_frame_packer.sv
// tb_dbg_frame_packer
//  Two packers (MSB-first and LSB-first data order) share the same stimulus.
//  A transfer-level model builds the expected byte stream from the frame
//  rules; every cycle the bench checks valid/data/done/busy/frame_count
//  against it while randomizing sink back-pressure and source stalls.
module tb_dbg_frame_packer;
   import dbg_frame_pkg::*;

   localparam int MAX_LEN = 128;
   localparam int CNT_W   = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dbg_frame_packer_if #(.CNT_W(CNT_W)) bus_m ();
   dbg_frame_packer_if #(.CNT_W(CNT_W)) bus_l ();

   dbg_frame_packer #(.MAX_LEN(MAX_LEN), .CMD_WRITE(8'h10), .DATA_MSB_FIRST(1'b1), .CNT_W(CNT_W))
      dut_msb (.clk_i(clk), .rst_i(rst), .bus(bus_m));
   dbg_frame_packer #(.MAX_LEN(MAX_LEN), .CMD_WRITE(8'h10), .DATA_MSB_FIRST(1'b0), .CNT_W(CNT_W))
      dut_lsb (.clk_i(clk), .rst_i(rst), .bus(bus_l));

   assign bus_l.start_i       = bus_m.start_i;
   assign bus_l.base_addr_i   = bus_m.base_addr_i;
   assign bus_l.total_words_i = bus_m.total_words_i;
   assign bus_l.word_valid_i  = bus_m.word_valid_i;
   assign bus_l.word_data_i   = bus_m.word_data_i;
   assign bus_l.byte_accept_i = bus_m.byte_accept_i;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [7:0] msb;
      logic [7:0] lsb;
      int         tag;   // source word index for data bytes, -1 for header
      bit         last;  // final byte of a frame
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] words[$];
   int          exp_frames;

   // Expected stream straight from the frame rules.
   task automatic build_model(input logic [31:0] base, input int n);
      int          rem, wi, len;
      logic [31:0] addr;
      exp_q.delete();
      rem = n; addr = base; wi = 0; exp_frames = 0;
      while (rem > 0) begin
         len = (4 * rem > MAX_LEN) ? MAX_LEN : 4 * rem;
         exp_q.push_back('{8'h10, 8'h10, -1, 1'b0});
         exp_q.push_back('{8'(len), 8'(len), -1, 1'b0});
         for (int b = 3; b >= 0; b--)
            exp_q.push_back('{addr[8*b +: 8], addr[8*b +: 8], -1, 1'b0});
         for (int w = 0; w < len / 4; w++) begin
            for (int b = 0; b < 4; b++)
               exp_q.push_back('{words[wi][8*(3-b) +: 8], words[wi][8*b +: 8], wi,
                                 (w == len / 4 - 1) && (b == 3)});
            wi++;
         end
         rem  -= len / 4;
         addr += 32'(len);
         exp_frames++;
      end
   endtask

   task automatic run_transfer(input string name, input logic [31:0] base, input int n,
                               input int acc_pct, input int stall_pct,
                               input int long_stall_at, input int abort_at);
      int         wi, popped, frames_done, long_cnt, bytes_seen;
      bit         finished, prev_bv, prev_acc;
      logic [7:0] prev_bd_m, prev_bd_l;
      logic       bv_m, bv_l, wa_m, dn_m;
      logic [7:0] bd_m, bd_l;
      build_model(base, n);
      @(negedge clk);
      bus_m.start_i       = 1'b1;
      bus_m.base_addr_i   = base;
      bus_m.total_words_i = CNT_W'(n);
      bus_m.byte_accept_i = 1'b0;
      bus_m.word_valid_i  = 1'b0;
      wi = 0; popped = 0; frames_done = 0; long_cnt = 0; bytes_seen = 0;
      finished = 0; prev_bv = 0; prev_acc = 0; prev_bd_m = '0; prev_bd_l = '0;
      for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
         @(negedge clk);
         if (abort_at >= 0 && popped == abort_at) begin
            bus_m.start_i = 1'b0; bus_m.byte_accept_i = 1'b0; bus_m.word_valid_i = 1'b0;
            rst = 1'b1;
            @(negedge clk); #1;
            check({name, " rst valid"}, 64'(bus_m.byte_valid_o), 64'd0);
            check({name, " rst data"}, 64'(bus_m.byte_data_o), 64'd0);
            check({name, " rst busy"}, 64'(bus_m.busy_o), 64'd0);
            check({name, " rst done"}, 64'(bus_m.done_o), 64'd0);
            check({name, " rst fcnt"}, 64'(bus_m.frame_count_o), 64'd0);
            check({name, " rst waccept"}, 64'(bus_m.word_accept_o), 64'd0);
            check({name, " rst valid lsb"}, 64'(bus_l.byte_valid_o), 64'd0);
            rst = 1'b0;
            finished = 1;
         end else begin
            bus_m.start_i       = ($urandom_range(0, 9) == 0);
            bus_m.base_addr_i   = $urandom;
            bus_m.total_words_i = CNT_W'($urandom_range(0, 60));
            bus_m.byte_accept_i = ($urandom_range(0, 99) < acc_pct);
            if (wi == long_stall_at && long_cnt < 10) begin
               bus_m.word_valid_i = 1'b0;
               long_cnt++;
            end else begin
               bus_m.word_valid_i = (wi < n) && ($urandom_range(0, 99) >= stall_pct);
            end
            bus_m.word_data_i = (wi < n) ? words[wi] : $urandom;
            #1;
            bv_m = bus_m.byte_valid_o; bd_m = bus_m.byte_data_o;
            bv_l = bus_l.byte_valid_o; bd_l = bus_l.byte_data_o;
            wa_m = bus_m.word_accept_o; dn_m = bus_m.done_o;
            if (exp_q.size() != 0) begin
               check({name, " valid"}, 64'(bv_m), 64'(exp_q[0].tag < wi));
               check({name, " valid lsb"}, 64'(bv_l), 64'(exp_q[0].tag < wi));
               if (bv_m) check($sformatf("%s byte%0d", name, bytes_seen), 64'(bd_m), 64'(exp_q[0].msb));
               if (bv_l) check($sformatf("%s lsb byte%0d", name, bytes_seen), 64'(bd_l), 64'(exp_q[0].lsb));
            end else begin
               check({name, " valid after end"}, 64'(bv_m), 64'd0);
            end
            if (prev_bv && !prev_acc) begin
               check({name, " hold data"}, {bv_m, bd_m}, {1'b1, prev_bd_m});
               check({name, " hold data lsb"}, {bv_l, bd_l}, {1'b1, prev_bd_l});
            end
            check({name, " done"}, 64'(dn_m), 64'(exp_q.size() == 0));
            check({name, " done lsb"}, 64'(bus_l.done_o), 64'(exp_q.size() == 0));
            check({name, " busy"}, 64'(bus_m.busy_o), 64'(exp_q.size() != 0));
            check({name, " fcnt"}, 64'(bus_m.frame_count_o), 64'(frames_done));
            prev_bv = bv_m; prev_acc = bus_m.byte_accept_i;
            prev_bd_m = bd_m; prev_bd_l = bd_l;
            if (bv_m && bus_m.byte_accept_i && exp_q.size() != 0) begin
               if (exp_q[0].last) frames_done++;
               void'(exp_q.pop_front());
               popped++;
               bytes_seen++;
            end
            if (bus_m.word_valid_i && wa_m) wi++;
            if (dn_m) begin
               check({name, " frames"}, 64'(bus_m.frame_count_o), 64'(exp_frames));
               check({name, " words used"}, 64'(wi), 64'(n));
               finished = 1;
            end
         end
      end
      if (!finished) check({name, " timeout"}, 64'd0, 64'd1);
      bus_m.start_i = 1'b0; bus_m.byte_accept_i = 1'b0; bus_m.word_valid_i = 1'b0;
      $display("transfer %s: base=0x%08h words=%0d frames=%0d bytes=%0d", name, base, n,
               exp_frames, bytes_seen);
   endtask

   task automatic rand_words(input int n);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
   endtask

   initial begin
      rst = 1'b1;
      bus_m.start_i = 1'b0; bus_m.base_addr_i = '0; bus_m.total_words_i = '0;
      bus_m.word_valid_i = 1'b0; bus_m.word_data_i = '0; bus_m.byte_accept_i = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset valid", 64'(bus_m.byte_valid_o), 64'd0);
      check("reset data", 64'(bus_m.byte_data_o), 64'd0);
      check("reset busy", 64'(bus_m.busy_o), 64'd0);
      check("reset done", 64'(bus_m.done_o), 64'd0);
      check("reset fcnt", 64'(bus_m.frame_count_o), 64'd0);
      check("reset waccept", 64'(bus_m.word_accept_o), 64'd0);
      rst = 1'b0;

      words.delete();
      words.push_back(32'hAABBCCDD);
      words.push_back(32'h11223344);
      run_transfer("two_words", 32'h1000_0000, 2, 100, 0, -1, -1);

      rand_words(40);
      run_transfer("forty", 32'h0, 40, 100, 0, -1, -1);
      run_transfer("forty_bp", 32'h0, 40, 30, 0, -1, -1);

      words.delete();
      run_transfer("zero", 32'h1234_5678, 0, 100, 0, -1, -1);

      rand_words(8);
      run_transfer("src_stall", 32'h0000_2000, 8, 100, 0, 3, -1);

      rand_words(40);
      run_transfer("reset_mid", 32'h0000_4000, 40, 70, 10, -1, 137);
      rand_words(3);
      run_transfer("after_rst", 32'h0000_5000, 3, 100, 0, -1, -1);

      rand_words(40);
      run_transfer("wrap", 32'hFFFF_FFC0, 40, 60, 20, -1, -1);

      for (int t = 0; t < 5; t++) begin
         int n;
         n = $urandom_range(1, 90);
         rand_words(n);
         run_transfer($sformatf("rand%0d", t), $urandom, n,
                      $urandom_range(40, 100), $urandom_range(0, 40), -1, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
